monit_cmd_rx: RTL and testbench
===============================

# monit_cmd_rx

Receive-side frame decoder for the monitor UART link: consumes bytes delivered by the UART Rx unit and parses host→FPGA parameter-write frames. Frames use the same word format as the outgoing monitor stream: 32-bit words sent MSB byte first, `@`-prefixed variable IDs, and value words. Each valid ID/value pair produces a single-cycle register-write strobe toward the parameter bank. Sits between the comUnit Rx output and the control-parameter registers.

## Interface
- `NUMBER_OF_PARAMS`, default 8: number of writable parameters. Valid indices are 0..NUMBER_OF_PARAMS-1; maximum is 10.
- `VARIABLE_LENGTH`, default 32: word width in bits. Fixed at 4 bytes.
- `TIMEOUT_CLKS`, default 2000: maximum idle clocks between bytes inside a frame. Used only with the timeout feature.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-low.
- `rx_data` in 8: received byte. Valid only while `rx_valid` is high.
- `rx_valid` in 1: one-cycle strobe per received byte (the doneRx signal).
- `wr_en` out 1: one-cycle parameter write strobe.
- `wr_index` out 8: parameter index. Held until the next write.
- `wr_data` out 32: parameter value. Held until the next write.
- `frame_done` out 1: one-cycle pulse when a frame completes with a good trailer.
- `frame_err` out 1: one-cycle pulse when a frame is aborted.
- `err_code` out 3: cause of the last abort. Held until the next header is detected.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- Frame layout, all words MSB first:
  - HEADER 0x2F2F0D0A (`//\r\n`)
  - COUNT word N
  - N × (ID word, VALUE word)
  - TRAILER 0x5C5C0D0A (`\\\r\n`)
- FSM states: IDLE, COUNT, ID, VALUE, TRAILER.
- IDLE:
  - Each accepted byte shifts into a 32-bit hunt register.
  - When the register equals HEADER, go to COUNT, clear `err_code` and the byte counter.
  - Partial or garbage bytes are silently discarded.
- Word assembly: a 2-bit byte counter and shift register. A word is complete on the 4th accepted byte of the field.
- COUNT:
  - N=0 → TRAILER.
  - 1≤N≤NUMBER_OF_PARAMS → ID, with the pair counter loaded to N.
  - N>NUMBER_OF_PARAMS → abort, `err_code`=1.
- ID:
  - Accepted word is 0x40 0x30 0x30 (0x30+k) with k<NUMBER_OF_PARAMS; latch k and go to VALUE.
  - Anything else → abort, `err_code`=2.
- VALUE:
  - On word completion: `wr_index`=k, `wr_data`=word, `wr_en` pulse.
  - Decrement the pair counter; if it reaches 0 → TRAILER, else → ID.
- TRAILER:
  - Word equals TRAILER → `frame_done` pulse, IDLE.
  - Otherwise → abort, `err_code`=3.
- Abort: `frame_err` pulse, return to IDLE, clear the hunt register. Writes already issued in the frame are not rolled back.
- Repeated IDs within one frame are each written, in order.

## Timing
- Reset values: `wr_en`=0, `wr_index`=0, `wr_data`=0, `frame_done`=0, `frame_err`=0, `err_code`=0, `busy`=0, FSM=IDLE, all counters=0.
- A byte is accepted on the rising edge where `rx_valid`=1.
- `wr_en`, `frame_done` and `frame_err` are registered. Each asserts on the edge that accepts the word's 4th byte, so it is visible the following cycle, for exactly one cycle.
- Back-to-back `rx_valid` on consecutive cycles must be handled with no byte loss.
- HEADER may be detected in the same cycle as an abort of the previous frame only via a fresh hunt. No overlap: the hunt register restarts empty after an abort.
- `rst` asserted mid-frame: everything returns to reset values immediately, with no pulse output.

## Configuration
- `MONIT_CMD_RX_TIMEOUT_EN` defined:
  - A 32-bit idle counter clears on every accepted byte and counts while FSM≠IDLE.
  - On reaching TIMEOUT_CLKS → abort with `err_code`=4.
- Not defined: no counter is instantiated, and a stalled frame waits indefinitely, with `busy` held high.

## Structure
- `monit_pkg` holds:
  - HEADER_WORD, TRAILER_WORD, ID_PREFIX (0x403030)
  - FSM state encoding
  - error codes: ERR_NONE=0, ERR_COUNT=1, ERR_ID=2, ERR_TRAILER=3, ERR_TIMEOUT=4
- Sub-module `monit_word_asm`: byte counter plus shift register, with `clear`, `byte_valid`, `byte_in` inputs and `word`, `word_valid` outputs. It is reused for the hunt-free fields.

## Test plan
- Frame with HEADER, N=2, (@001, 0x12345678), (@003, 0xDEADBEEF), TRAILER → `wr_en` twice, with (1, 0x12345678) then (3, 0xDEADBEEF), then `frame_done`=1 once.
- Garbage 0xAA 0x2F then a full N=0 frame → no `wr_en`, one `frame_done`.
- N=11 with NUMBER_OF_PARAMS=8 → `frame_err`, `err_code`=1. A following valid frame is still decoded.
- ID word 0x40303039 → `frame_err`, `err_code`=2. Trailer 0x5C5C0D0B → `err_code`=3 after the writes complete.
- With `MONIT_CMD_RX_TIMEOUT_EN`, stall TIMEOUT_CLKS after the COUNT word → `frame_err`, `err_code`=4, `busy`=0. Separately, drive `rst` low mid-VALUE → all outputs 0, and the next frame decodes normally.

Source files
------------

// File: rtl/monit_pkg.sv
// Shared constants, FSM encoding and abort codes for the monitor command receiver.
package monit_pkg;

  localparam logic [31:0] HEADER_WORD  = 32'h2F2F0D0A;
  localparam logic [31:0] TRAILER_WORD = 32'h5C5C0D0A;
  localparam logic [23:0] ID_PREFIX    = 24'h403030;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COUNT   = 3'd1,
    ST_ID      = 3'd2,
    ST_VALUE   = 3'd3,
    ST_TRAILER = 3'd4
  } monit_state_e;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_COUNT   = 3'd1;
  localparam logic [2:0] ERR_ID      = 3'd2;
  localparam logic [2:0] ERR_TRAILER = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;

endpackage

// File: rtl/monit_word_asm.sv
// Assembles four bytes (MSB first) into a 32-bit word; word_valid flags the 4th byte.
module monit_word_asm
  import monit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] shift_q, shift_d;

  // The completed word includes the byte arriving this cycle, so the FSM can act on it at once.
  always_comb begin
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    word       = {shift_q, byte_in};
    word_valid = byte_valid && (cnt_q == 2'd3);
    if (clear) begin
      cnt_d   = 2'd0;
      shift_d = 24'd0;
    end else if (byte_valid) begin
      cnt_d   = cnt_q + 2'd1;
      shift_d = {shift_q[15:0], byte_in};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= 2'd0;
      shift_q <= 24'd0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/monit_cmd_rx.sv
// Host-to-FPGA parameter-write frame decoder for the monitor UART link.
// Optional inter-byte timeout enabled by defining MONIT_CMD_RX_TIMEOUT_EN.
// Handshake: a byte is taken on every rising edge with rx_valid=1 (no backpressure);
// wr_en/frame_done/frame_err are single-cycle registered strobes.
module monit_cmd_rx
  import monit_pkg::*;
#(
  parameter int NUMBER_OF_PARAMS = 8,
  parameter int VARIABLE_LENGTH  = 32,
  parameter int TIMEOUT_CLKS     = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        wr_en,
  output logic [7:0]  wr_index,
  output logic [31:0] wr_data,
  output logic        frame_done,
  output logic        frame_err,
  output logic [2:0]  err_code,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  if (NUMBER_OF_PARAMS < 1 || NUMBER_OF_PARAMS > 10) begin : g_bad_params
    $error("NUMBER_OF_PARAMS must be 1..10");
  end
  if (VARIABLE_LENGTH != 32) begin : g_bad_width
    $error("VARIABLE_LENGTH is fixed at 32");
  end
  if (TIMEOUT_CLKS < 1) begin : g_bad_timeout
    $error("TIMEOUT_CLKS must be positive");
  end

  monit_state_e state_q, state_d;
  logic [31:0]  hunt_q, hunt_d;
  logic [3:0]   pair_q, pair_d;
  logic [3:0]   k_q, k_d;
  logic         wr_en_q, wr_en_d;
  logic [7:0]   wr_index_q, wr_index_d;
  logic [31:0]  wr_data_q, wr_data_d;
  logic         frame_done_q, frame_done_d;
  logic         frame_err_q, frame_err_d;
  logic [2:0]   err_code_q, err_code_d;

  logic         asm_clear;
  logic         asm_byte_valid;
  logic [31:0]  word;
  logic         word_valid;
  logic         abort;
  logic [2:0]   abort_code;
  logic [7:0]   id_char;
  logic [7:0]   id_k;
  logic         id_ok;

  // The hunt register owns the bytes while idle; field bytes go to the assembler.
  assign asm_byte_valid = rx_valid && (state_q != ST_IDLE);

  monit_word_asm u_word_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (asm_clear),
    .byte_valid (asm_byte_valid),
    .byte_in    (rx_data),
    .word       (word),
    .word_valid (word_valid)
  );

  assign id_char = word[7:0];
  assign id_k    = id_char - 8'h30;
  assign id_ok   = (word[31:8] == ID_PREFIX) && (id_char >= 8'h30) &&
                   (id_k < 8'(NUMBER_OF_PARAMS));

`ifdef MONIT_CMD_RX_TIMEOUT_EN
  logic [31:0] idle_cnt_q, idle_cnt_d;
  logic        timeout_hit;

  always_comb begin
    idle_cnt_d  = 32'd0;
    timeout_hit = 1'b0;
    if (state_q != ST_IDLE && !rx_valid) begin
      idle_cnt_d  = idle_cnt_q + 32'd1;
      timeout_hit = (idle_cnt_d == 32'(TIMEOUT_CLKS));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idle_cnt_q <= 32'd0;
    else      idle_cnt_q <= idle_cnt_d;
  end
`else
  logic timeout_hit;
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    hunt_d       = hunt_q;
    pair_d       = pair_q;
    k_d          = k_q;
    wr_en_d      = 1'b0;
    wr_index_d   = wr_index_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    err_code_d   = err_code_q;
    asm_clear    = 1'b0;
    abort        = 1'b0;
    abort_code   = ERR_NONE;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          hunt_d = {hunt_q[23:0], rx_data};
          if (hunt_d == HEADER_WORD) begin
            state_d    = ST_COUNT;
            err_code_d = ERR_NONE;
            asm_clear  = 1'b1;
            hunt_d     = 32'd0;
          end
        end
      end
      ST_COUNT: begin
        if (word_valid) begin
          if (word == 32'd0) begin
            state_d = ST_TRAILER;
          end else if (word <= 32'(NUMBER_OF_PARAMS)) begin
            state_d = ST_ID;
            pair_d  = word[3:0];
          end else begin
            abort      = 1'b1;
            abort_code = ERR_COUNT;
          end
        end
      end
      ST_ID: begin
        if (word_valid) begin
          if (id_ok) begin
            k_d     = id_k[3:0];
            state_d = ST_VALUE;
          end else begin
            abort      = 1'b1;
            abort_code = ERR_ID;
          end
        end
      end
      ST_VALUE: begin
        if (word_valid) begin
          wr_en_d    = 1'b1;
          wr_index_d = {4'd0, k_q};
          wr_data_d  = word;
          pair_d     = pair_q - 4'd1;
          state_d    = (pair_q == 4'd1) ? ST_TRAILER : ST_ID;
        end
      end
      ST_TRAILER: begin
        if (word_valid) begin
          if (word == TRAILER_WORD) begin
            frame_done_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            abort      = 1'b1;
            abort_code = ERR_TRAILER;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A timeout can only fire on a cycle without a byte, so it never collides with a word abort.
    if (timeout_hit) begin
      abort      = 1'b1;
      abort_code = ERR_TIMEOUT;
    end

    if (abort) begin
      frame_err_d = 1'b1;
      err_code_d  = abort_code;
      state_d     = ST_IDLE;
      hunt_d      = 32'd0;
      pair_d      = 4'd0;
      asm_clear   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      hunt_q       <= 32'd0;
      pair_q       <= 4'd0;
      k_q          <= 4'd0;
      wr_en_q      <= 1'b0;
      wr_index_q   <= 8'd0;
      wr_data_q    <= 32'd0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      hunt_q       <= hunt_d;
      pair_q       <= pair_d;
      k_q          <= k_d;
      wr_en_q      <= wr_en_d;
      wr_index_q   <= wr_index_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      err_code_q   <= err_code_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_index   = wr_index_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign err_code   = err_code_q;
  assign busy       = (state_q != ST_IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_monit_cmd_rx.sv
// Directed self-checking bench for monit_cmd_rx: frame decode, error aborts, reset mid-frame.
module tb_monit_cmd_rx;

  localparam int NP      = 8;
  localparam int TIMEOUT = 2000;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        wr_en;
  logic [7:0]  wr_index;
  logic [31:0] wr_data;
  logic        frame_done;
  logic        frame_err;
  logic [2:0]  err_code;
  logic        busy;
  logic [2:0]  dbg_state;

  int n_checks;
  int n_errors;
  int done_cnt;
  int err_cnt;
  logic [39:0] exp_q[$];

  monit_cmd_rx #(
    .NUMBER_OF_PARAMS (NP),
    .VARIABLE_LENGTH  (32),
    .TIMEOUT_CLKS     (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .wr_en      (wr_en),
    .wr_index   (wr_index),
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .err_code   (err_code),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_wr(input logic [7:0] idx, input logic [31:0] val);
    exp_q.push_back({idx, val});
  endtask

  // scoreboard: every wr_en pulse must match the head of exp_q
  always @(negedge clk) begin
    if (rst) begin
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          chk("wr_unexpected", 64'd1, 64'd0);
        end else begin
          logic [39:0] e;
          e = exp_q.pop_front();
          chk("wr_index", {56'd0, wr_index}, {56'd0, e[39:32]});
          chk("wr_data", {32'd0, wr_data}, {32'd0, e[31:0]});
        end
      end
      if (frame_done) done_cnt++;
      if (frame_err)  err_cnt++;
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    done_cnt = 0;
    err_cnt  = 0;
    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle(3);
    chk("rst_wr_en", {63'd0, wr_en}, 64'd0);
    chk("rst_wr_index", {56'd0, wr_index}, 64'd0);
    chk("rst_wr_data", {32'd0, wr_data}, 64'd0);
    chk("rst_done_err", {62'd0, frame_done, frame_err}, 64'd0);
    chk("rst_err_code", {61'd0, err_code}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    rst = 1'b1;
    idle(2);

    // Two writes, back-to-back bytes throughout
    expect_wr(8'd1, 32'h12345678);
    expect_wr(8'd3, 32'hDEADBEEF);
    send_word(32'h2F2F0D0A);
    chk("hdr_busy", {63'd0, busy}, 64'd1);
    chk("hdr_state", {61'd0, dbg_state}, 64'd1);
    send_word(32'd2);
    send_word(32'h40303031);
    send_word(32'h12345678);
    send_word(32'h40303033);
    send_word(32'hDEADBEEF);
    send_word(32'h5C5C0D0A);
    idle(2);
    chk("t1_done", done_cnt, 1);
    chk("t1_err", err_cnt, 0);
    chk("t1_pending", exp_q.size(), 0);
    chk("t1_hold_idx", {56'd0, wr_index}, 64'd3);
    chk("t1_hold_data", {32'd0, wr_data}, 64'hDEADBEEF);
    chk("t1_busy", {63'd0, busy}, 64'd0);

    // Garbage ahead of an empty frame
    send_byte(8'hAA);
    send_byte(8'h2F);
    send_word(32'h2F2F0D0A);
    send_word(32'd0);
    send_word(32'h5C5C0D0A);
    idle(2);
    chk("t2_done", done_cnt, 2);
    chk("t2_err", err_cnt, 0);

    // Count too large, then a good frame with the highest index
    send_word(32'h2F2F0D0A);
    send_word(32'd11);
    idle(1);
    chk("t3_err", err_cnt, 1);
    chk("t3_code", {61'd0, err_code}, 64'd1);
    chk("t3_busy", {63'd0, busy}, 64'd0);
    expect_wr(8'd7, 32'hCAFEF00D);
    send_word(32'h2F2F0D0A);
    chk("t3_code_clr", {61'd0, err_code}, 64'd0);
    send_word(32'd1);
    send_word(32'h40303037);
    send_word(32'hCAFEF00D);
    send_word(32'h5C5C0D0A);
    idle(2);
    chk("t3_done", done_cnt, 3);
    chk("t3_pending", exp_q.size(), 0);

    // Index 9 is out of range
    send_word(32'h2F2F0D0A);
    send_word(32'd1);
    send_word(32'h40303039);
    idle(1);
    chk("t4_err", err_cnt, 2);
    chk("t4_code", {61'd0, err_code}, 64'd2);

    // Repeated ID, writes land, then a bad trailer
    expect_wr(8'd0, 32'h00000001);
    expect_wr(8'd0, 32'h00000002);
    send_word(32'h2F2F0D0A);
    send_word(32'd2);
    send_word(32'h40303030);
    send_word(32'h00000001);
    send_word(32'h40303030);
    send_word(32'h00000002);
    send_word(32'h5C5C0D0B);
    idle(1);
    chk("t5_err", err_cnt, 3);
    chk("t5_code", {61'd0, err_code}, 64'd3);
    chk("t5_pending", exp_q.size(), 0);
    chk("t5_done", done_cnt, 3);

    // Full count with gaps between bytes
    send_word(32'h2F2F0D0A);
    send_word(NP);
    for (int i = 0; i < NP; i++) begin
      expect_wr(8'(i), 32'h11111111 * (i + 1));
      send_word({24'h403030, 8'h30 + 8'(i)});
      idle(2);
      send_word(32'h11111111 * (i + 1));
    end
    send_word(32'h5C5C0D0A);
    idle(2);
    chk("t6_done", done_cnt, 4);
    chk("t6_pending", exp_q.size(), 0);

`ifdef MONIT_CMD_RX_TIMEOUT_EN
    send_word(32'h2F2F0D0A);
    send_word(32'd1);
    idle(TIMEOUT + 3);
    chk("to_err", err_cnt, 4);
    chk("to_code", {61'd0, err_code}, 64'd4);
    chk("to_busy", {63'd0, busy}, 64'd0);
`endif

    // Reset in the middle of a VALUE word
    begin
      int d0, e0;
      d0 = done_cnt;
      e0 = err_cnt;
      send_word(32'h2F2F0D0A);
      send_word(32'd1);
      send_word(32'h40303032);
      send_byte(8'h55);
      send_byte(8'h66);
      rst = 1'b0;
      #1;
      chk("mr_wr_en", {63'd0, wr_en}, 64'd0);
      chk("mr_wr_index", {56'd0, wr_index}, 64'd0);
      chk("mr_wr_data", {32'd0, wr_data}, 64'd0);
      chk("mr_busy", {63'd0, busy}, 64'd0);
      chk("mr_err_code", {61'd0, err_code}, 64'd0);
      idle(2);
      rst = 1'b1;
      idle(2);
      chk("mr_no_pulse", {32'(done_cnt - d0), 32'(err_cnt - e0)}, 64'd0);
      expect_wr(8'd5, 32'h0BADC0DE);
      send_word(32'h2F2F0D0A);
      send_word(32'd1);
      send_word(32'h40303035);
      send_word(32'h0BADC0DE);
      send_word(32'h5C5C0D0A);
      idle(2);
      chk("mr_done", done_cnt - d0, 1);
      chk("mr_pending", exp_q.size(), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
